// File: rtl/dmem_arbiter.sv
// Single-port data memory arbiter: CPU has fixed priority, DMA gets a starvation guard.
// Define DMEM_ARB_PERF_EN to add the stall_cyc_o / dma_xfer_o performance counters.
module dmem_arbiter #(
    parameter int unsigned ADDR_W     = 32,
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned MEM_LAT    = 1,
    parameter int unsigned STARVE_LIM = 4
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              cpu_req_i,
    input  logic              cpu_we_i,
    input  logic [ADDR_W-1:0] cpu_addr_i,
    input  logic [DATA_W-1:0] cpu_wdata_i,
    output logic [DATA_W-1:0] cpu_rdata_o,
    output logic              cpu_done_o,
    output logic              cpu_stall_o,
    input  logic              dma_req_i,
    input  logic              dma_we_i,
    input  logic [ADDR_W-1:0] dma_addr_i,
    input  logic [DATA_W-1:0] dma_wdata_i,
    output logic [DATA_W-1:0] dma_rdata_o,
    output logic              dma_done_o,
    output logic              mem_en_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    input  logic [DATA_W-1:0] mem_rdata_i
`ifdef DMEM_ARB_PERF_EN
    ,
    output logic [31:0]       stall_cyc_o,
    output logic [31:0]       dma_xfer_o
`endif
);

    localparam int unsigned LAT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
    localparam int unsigned STV_W = (STARVE_LIM > 0) ? $clog2(STARVE_LIM + 1) : 1;
    localparam logic [LAT_W-1:0] LAT_INIT = LAT_W'(MEM_LAT - 1);
    localparam logic [STV_W-1:0] STV_MAX  = STV_W'(STARVE_LIM);

    typedef enum logic [1:0] {ST_IDLE, ST_BUSY, ST_DONE} state_e;
    typedef enum logic {OWN_CPU, OWN_DMA} owner_e;

    state_e            state_q, state_d;
    owner_e            owner_q, owner_d;
    logic [LAT_W-1:0]  lat_cnt_q, lat_cnt_d;
    logic [STV_W-1:0]  starve_cnt_q, starve_cnt_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] cpu_rdata_q, cpu_rdata_d;
    logic [DATA_W-1:0] dma_rdata_q, dma_rdata_d;
    logic              grant_dma;

    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        lat_cnt_d    = lat_cnt_q;
        starve_cnt_d = starve_cnt_q;
        we_d         = we_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        cpu_rdata_d  = cpu_rdata_q;
        dma_rdata_d  = dma_rdata_q;
        grant_dma    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (cpu_req_i || dma_req_i) begin
                    // DMA wins when alone, or when the CPU has held it off STARVE_LIM times
                    grant_dma = dma_req_i &&
                                (!cpu_req_i || (STARVE_LIM != 0 && starve_cnt_q == STV_MAX));
                    owner_d   = grant_dma ? OWN_DMA : OWN_CPU;
                    we_d      = grant_dma ? dma_we_i : cpu_we_i;
                    addr_d    = grant_dma ? dma_addr_i : cpu_addr_i;
                    wdata_d   = grant_dma ? dma_wdata_i : cpu_wdata_i;
                    lat_cnt_d = LAT_INIT;
                    if (grant_dma || !dma_req_i) begin
                        starve_cnt_d = '0;
                    end else if (starve_cnt_q != STV_MAX) begin
                        starve_cnt_d = starve_cnt_q + 1'b1;
                    end
                    state_d = ST_BUSY;
                end
            end
            ST_BUSY: begin
                if (lat_cnt_q == '0) begin
                    if (owner_q == OWN_DMA) begin
                        dma_rdata_d = mem_rdata_i;
                    end else begin
                        cpu_rdata_d = mem_rdata_i;
                    end
                    state_d = ST_DONE;
                end else begin
                    lat_cnt_d = lat_cnt_q - 1'b1;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= ST_IDLE;
            owner_q      <= OWN_CPU;
            lat_cnt_q    <= '0;
            starve_cnt_q <= '0;
            we_q         <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            cpu_rdata_q  <= '0;
            dma_rdata_q  <= '0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            lat_cnt_q    <= lat_cnt_d;
            starve_cnt_q <= starve_cnt_d;
            we_q         <= we_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            cpu_rdata_q  <= cpu_rdata_d;
            dma_rdata_q  <= dma_rdata_d;
        end
    end

    always_comb begin
        mem_en_o    = (state_q == ST_BUSY);
        mem_we_o    = (state_q == ST_BUSY) && we_q;
        mem_addr_o  = addr_q;
        mem_wdata_o = wdata_q;
        cpu_done_o  = (state_q == ST_DONE) && (owner_q == OWN_CPU);
        dma_done_o  = (state_q == ST_DONE) && (owner_q == OWN_DMA);
        cpu_rdata_o = cpu_rdata_q;
        dma_rdata_o = dma_rdata_q;
        cpu_stall_o = cpu_req_i && !cpu_done_o;
    end

`ifdef DMEM_ARB_PERF_EN
    logic [31:0] stall_cyc_q, stall_cyc_d;
    logic [31:0] dma_xfer_q, dma_xfer_d;

    always_comb begin
        stall_cyc_d = stall_cyc_q;
        dma_xfer_d  = dma_xfer_q;
        if (cpu_stall_o) begin
            stall_cyc_d = stall_cyc_q + 32'd1;
        end
        if (dma_done_o) begin
            dma_xfer_d = dma_xfer_q + 32'd1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            stall_cyc_q <= '0;
            dma_xfer_q  <= '0;
        end else begin
            stall_cyc_q <= stall_cyc_d;
            dma_xfer_q  <= dma_xfer_d;
        end
    end

    assign stall_cyc_o = stall_cyc_q;
    assign dma_xfer_o  = dma_xfer_q;
`endif

endmodule
